s2p_rr_scheduler: RTL and testbench

//   Shares one serial-to-parallel deserializer between NUM_CH serial requesters.

---
 rtl/s2p_rr_scheduler_if.sv | 34 +++
 rtl/s2p_rr_scheduler.sv | 154 +++++++++++++++
 tb/tb_s2p_rr_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/s2p_rr_scheduler_if.sv
// Bundle of the per-lane serial request/data lines and the parallel word output
// of the shared round-robin deserializer.
interface s2p_rr_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int WIDTH  = 8
);
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] ch_din_serial;
  logic [NUM_CH-1:0] grant;
  logic [WIDTH-1:0]  dout_parallel;
  logic [CH_W-1:0]   dout_ch;
  logic              dout_valid;

  // Serial sources plus word consumer side.
  modport master (
    output req,
    output ch_din_serial,
    input  grant,
    input  dout_parallel,
    input  dout_ch,
    input  dout_valid
  );

  // Scheduler side.
  modport slave (
    input  req,
    input  ch_din_serial,
    output grant,
    output dout_parallel,
    output dout_ch,
    output dout_valid
  );
endinterface

// File: rtl/s2p_rr_scheduler.sv
// Round-robin sharing of one serial-to-parallel deserializer among NUM_CH lanes;
// each granted frame is WIDTH bits MSB first, emitted with its source channel id.
module s2p_rr_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  s2p_rr_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   id;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  shift;
  logic [NUM_CH-1:0] grant;
  logic [WIDTH-1:0]  dout_parallel;
  logic [CH_W-1:0]   dout_ch;
  logic              dout_valid;

  logic              pick_valid;
  logic [CH_W-1:0]   pick_id;
  logic [CH_W-1:0]   cand;
  logic              granted_req;
  logic              granted_bit;
  logic [WIDTH-1:0]  shift_next;

  // Channel index base+off modulo NUM_CH; off never exceeds NUM_CH.
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NUM_CH)) begin
      sum = sum - 32'(NUM_CH);
    end else begin
      sum = sum;
    end
    return CH_W'(sum);
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = {NUM_CH{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first requesting lane strictly after ptr, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = {CH_W{1'b0}};
    cand       = {CH_W{1'b0}};
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = wrap_add(ptr, i);
      if (!pick_valid && bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end else begin
        pick_valid = pick_valid;
      end
    end
  end

  // Granted lane's request level and serial bit, and the shifted-in word.
  always_comb begin
    granted_req = bus.req[id];
    granted_bit = bus.ch_din_serial[id];
    shift_next  = {shift[WIDTH-2:0], granted_bit};
  end

  // Scheduler FSM: arbitration, shifting, word emission, abort handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= LAST_CH;
      id            <= {CH_W{1'b0}};
      cnt           <= {CNT_W{1'b0}};
      shift         <= {WIDTH{1'b0}};
      grant         <= {NUM_CH{1'b0}};
      dout_parallel <= {WIDTH{1'b0}};
      dout_ch       <= {CH_W{1'b0}};
      dout_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dout_valid <= 1'b0;
          cnt        <= {CNT_W{1'b0}};
          shift      <= {WIDTH{1'b0}};
          if (pick_valid) begin
            grant <= onehot(pick_id);
            id    <= pick_id;
            state <= SHIFT;
          end else begin
            grant <= {NUM_CH{1'b0}};
            state <= IDLE;
          end
        end
        SHIFT: begin
          // A lane that drops its request mid-frame forfeits its turn.
          if (!granted_req) begin
            grant <= {NUM_CH{1'b0}};
            shift <= {WIDTH{1'b0}};
            cnt   <= {CNT_W{1'b0}};
            ptr   <= id;
            state <= IDLE;
          end else if (cnt == LAST_BIT) begin
            dout_parallel <= shift_next;
            dout_ch       <= id;
            dout_valid    <= 1'b1;
            grant         <= {NUM_CH{1'b0}};
            shift         <= {WIDTH{1'b0}};
            cnt           <= {CNT_W{1'b0}};
            ptr           <= id;
            state         <= DONE;
          end else begin
            shift <= shift_next;
            cnt   <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            state <= SHIFT;
          end
        end
        DONE: begin
          dout_valid <= 1'b0;
          grant      <= {NUM_CH{1'b0}};
          state      <= IDLE;
        end
        default: begin
          grant      <= {NUM_CH{1'b0}};
          dout_valid <= 1'b0;
          cnt        <= {CNT_W{1'b0}};
          shift      <= {WIDTH{1'b0}};
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant         = grant;
  assign bus.dout_parallel = dout_parallel;
  assign bus.dout_ch       = dout_ch;
  assign bus.dout_valid    = dout_valid;

endmodule

// File: tb/tb_s2p_rr_scheduler.sv
// Scoreboard bench for s2p_rr_scheduler: directed frames push expected words,
// a monitor pops and compares on every dout_valid pulse.
module tb_s2p_rr_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int WIDTH  = 8;

  typedef struct {
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] lane_word [NUM_CH];

  s2p_rr_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .WIDTH(WIDTH)) bus ();

  s2p_rr_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.dout_valid !== 1'b1 && n < 40);
    if (bus.dout_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: no dout_valid within 40 cycles", name);
    end
  endtask

  task automatic wait_grant(input string name, output logic [NUM_CH-1:0] g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.grant === {NUM_CH{1'b0}} && n < 40);
    g = bus.grant;
    if (g === {NUM_CH{1'b0}}) begin
      checks++;
      errors++;
      $display("FAIL %s: no grant within 40 cycles", name);
    end
  endtask

  // Serial lane model: a granted lane presents bit k (MSB first) in its k-th grant cycle.
  initial begin
    int               bitidx [NUM_CH];
    logic [NUM_CH-1:0] prev;
    prev = {NUM_CH{1'b0}};
    bus.ch_din_serial = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) bitidx[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.grant[i] === 1'b1) begin
          bitidx[i] = (prev[i] === 1'b1) ? bitidx[i] + 1 : 0;
          bus.ch_din_serial[i] = lane_word[i][WIDTH-1-bitidx[i]];
        end else begin
          bus.ch_din_serial[i] = 1'($urandom_range(1, 0));
        end
      end
      prev = bus.grant;
    end
  end

  // Monitor: grant legality every cycle, scoreboard compare on each output word.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("grant_onehot0", {31'd0, $onehot0(bus.grant)}, 32'd1);
      if (bus.dout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: ch=%0d word=0x%0h with empty scoreboard",
                   bus.dout_ch, bus.dout_parallel);
        end else begin
          e = exp_q.pop_front();
          check("dout_ch", 32'(bus.dout_ch), 32'(e.ch));
          check("dout_parallel", 32'(bus.dout_parallel), 32'(e.data));
        end
      end
    end
  end

  initial begin
    int                n;
    int                gcount;
    int                pulses;
    int                t_prev;
    logic [NUM_CH-1:0] g;
    logic [NUM_CH-1:0] seen;

    for (int i = 0; i < NUM_CH; i++) lane_word[i] = 8'h00;
    bus.req = 4'b1111;
    rst     = 1'b1;

    // Reset with all lanes requesting; ch0 must win first.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_parallel", 32'(bus.dout_parallel), 32'd0);
    check("rst_ch", 32'(bus.dout_ch), 32'd0);
    lane_word[0] = 8'h3C;
    push(2'd0, 8'h3C);
    rst = 1'b0;
    @(negedge clk);
    check("first_grant", 32'(bus.grant), 32'h1);
    bus.req = 4'b0001;
    wait_valid("t1_frame", n);
    bus.req = 4'b0000;
    @(negedge clk);

    // Single frame on lane2: 8 grant cycles, pulse 9 cycles after sampling edge.
    lane_word[2] = 8'hA5;
    push(2'd2, 8'hA5);
    bus.req = 4'b0100;
    n = 0;
    gcount = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.grant === 4'b0100) gcount++;
    end while (bus.dout_valid !== 1'b1 && n < 40);
    check("t2_latency", 32'(n), 32'd9);
    check("t2_grant_cycles", 32'(gcount), 32'd8);
    check("t2_grant_low_in_done", 32'(bus.grant), 32'd0);
    bus.req = 4'b0000;

    // Fresh reset, then all lanes: order 0,1,2,3,0 with 10-cycle spacing.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    lane_word[0] = 8'h11;
    lane_word[1] = 8'h22;
    lane_word[2] = 8'h33;
    lane_word[3] = 8'h44;
    push(2'd0, 8'h11);
    push(2'd1, 8'h22);
    push(2'd2, 8'h33);
    push(2'd3, 8'h44);
    push(2'd0, 8'h11);
    bus.req = 4'b1111;
    rst = 1'b0;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_valid("t3_frame", n);
      if (k > 0) check("t3_spacing", 32'(cyc - t_prev), 32'd10);
      t_prev = cyc;
    end

    // Wrap/skip: lane3 frame leaves ptr=3, then only lanes 1 and 3 request.
    bus.req = 4'b1000;
    lane_word[3] = 8'h5A;
    push(2'd3, 8'h5A);
    wait_valid("t4_lane3", n);
    bus.req = 4'b1010;
    lane_word[1] = 8'hC3;
    lane_word[3] = 8'h96;
    push(2'd1, 8'hC3);
    push(2'd3, 8'h96);
    seen = 4'b0000;
    pulses = 0;
    n = 0;
    while (pulses < 2 && n < 60) begin
      @(negedge clk);
      n++;
      seen = seen | bus.grant;
      if (bus.dout_valid === 1'b1) pulses++;
    end
    bus.req = 4'b0000;
    check("t4_pulses", 32'(pulses), 32'd2);
    check("t4_granted_set", 32'(seen), 32'hA);

    // Abort: lane1 drops req in its 3rd shift cycle; lane2 (ptr+1) wins next.
    @(negedge clk);
    lane_word[1] = 8'hF0;
    bus.req = 4'b0010;
    wait_grant("t5_grant", g);
    check("t5_grant_lane1", 32'(g), 32'h2);
    repeat (2) @(negedge clk);
    bus.req = 4'b0101;
    lane_word[2] = 8'h69;
    @(negedge clk);
    check("t5_abort_grant", 32'(bus.grant), 32'd0);
    check("t5_abort_valid", 32'(bus.dout_valid), 32'd0);
    check("t5_abort_parallel", 32'(bus.dout_parallel), 32'h96);
    check("t5_abort_ch", 32'(bus.dout_ch), 32'd3);
    push(2'd2, 8'h69);
    @(negedge clk);
    check("t5_next_grant", 32'(bus.grant), 32'h4);
    wait_valid("t5_lane2", n);
    bus.req = 4'b0000;

    // Reset during the 5th shift cycle of a lane3 frame.
    @(negedge clk);
    lane_word[3] = 8'hE7;
    bus.req = 4'b1000;
    wait_grant("t6_grant", g);
    check("t6_grant_lane3", 32'(g), 32'h8);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_grant", 32'(bus.grant), 32'd0);
    check("t6_rst_valid", 32'(bus.dout_valid), 32'd0);
    check("t6_rst_parallel", 32'(bus.dout_parallel), 32'd0);
    check("t6_rst_ch", 32'(bus.dout_ch), 32'd0);
    bus.req = 4'b1111;
    @(negedge clk);
    lane_word[0] = 8'h0F;
    push(2'd0, 8'h0F);
    rst = 1'b0;
    @(negedge clk);
    check("t6_restart_grant", 32'(bus.grant), 32'h1);
    bus.req = 4'b0001;
    wait_valid("t6_lane0", n);
    bus.req = 4'b0000;
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
